// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: field layout, opcodes, states, write-back selects.
// Latency: none, constants and a pure combinational opcode classifier.
// Backpressure: not applicable.
package cpu_pkg;

   localparam int INSTR_W = 21;
   localparam int PC_W    = 8;
   localparam int RET_W   = 16;

   // Instruction field bit ranges
   localparam int OP_MSB = 20;
   localparam int OP_LSB = 17;
   localparam int RD_MSB = 16;
   localparam int RD_LSB = 14;
   localparam int OP_W   = OP_MSB - OP_LSB + 1;
   localparam int RD_W   = RD_MSB - RD_LSB + 1;

   // Opcodes; ALU operations occupy 0x0 up to OP_ALU_LAST
   localparam logic [OP_W-1:0] OP_ALU_LAST = 4'h6;
   localparam logic [OP_W-1:0] OP_LI       = 4'h8;
   localparam logic [OP_W-1:0] OP_LD       = 4'h9;
   localparam logic [OP_W-1:0] OP_ST       = 4'hA;
   localparam logic [OP_W-1:0] OP_HALT     = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
   } state_e;

   // Register-file write-back source
   typedef enum logic [1:0] {
      SEL_ALU = 2'd0,
      SEL_IMM = 2'd1,
      SEL_MEM = 2'd2
   } wr_sel_e;

   typedef enum logic [2:0] {
      CL_ALU, CL_LI, CL_LD, CL_ST, CL_HALT, CL_ILL
   } op_class_e;

   // Map a raw opcode onto the path it takes through the sequencer
   function automatic op_class_e op_classify(input logic [OP_W-1:0] op);
      op_class_e cls;
      if (op <= OP_ALU_LAST) begin
         cls = CL_ALU;
      end else begin
         case (op)
            OP_LI:   cls = CL_LI;
            OP_LD:   cls = CL_LD;
            OP_ST:   cls = CL_ST;
            OP_HALT: cls = CL_HALT;
            default: cls = CL_ILL;
         endcase
      end
      return cls;
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bundle of the sequencer's memory, decoder, register-file and status signals.
// Latency: none, wiring only.
// Backpressure: imem_valid and dmem_ack stall the sequencer while low.
interface instr_sequencer_if;
   import cpu_pkg::*;

   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_valid;
   logic [INSTR_W-1:0] imem_data;
   logic [INSTR_W-1:0] ir;
   logic               alu_go;
   logic               dmem_req;
   logic               dmem_we;
   logic               dmem_ack;
   logic               rf_we;
   logic [RD_W-1:0]    rf_wr_addr;
   logic [1:0]         rf_wr_sel;
   logic               busy;
   logic               illegal;
   logic               bus_error;
   logic [RET_W-1:0]   retired;

   // Sequencer side
   modport master (
      output imem_req, imem_addr, ir, alu_go, dmem_req, dmem_we,
             rf_we, rf_wr_addr, rf_wr_sel, busy, illegal, bus_error, retired,
      input  imem_valid, imem_data, dmem_ack
   );

   // Memory / datapath side
   modport slave (
      input  imem_req, imem_addr, ir, alu_go, dmem_req, dmem_we,
             rf_we, rf_wr_addr, rf_wr_sel, busy, illegal, bus_error, retired,
      output imem_valid, imem_data, dmem_ack
   );

endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer: FETCH, DECODE, then EXEC/MEM/WB per opcode; one instruction in flight.
// Latency: FETCH->FETCH is 3 cycles for LI, 4 for ALU, 3+ for LD/ST plus memory wait cycles.
// Backpressure: stalls in FETCH/MEM until valid/ack; WDOG_MAX missing cycles raise bus_error and halt.
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int WDOG_MAX = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_valid,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] ir,
   output logic               alu_go,
   output logic               dmem_req,
   output logic               dmem_we,
   input  logic               dmem_ack,
   output logic               rf_we,
   output logic [RD_W-1:0]    rf_wr_addr,
   output logic [1:0]         rf_wr_sel,
   output logic               busy,
   output logic               illegal,
   output logic               bus_error,
   output logic [RET_W-1:0]   retired
);

   localparam int WCW = $clog2(WDOG_MAX + 1);

   state_e             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [RET_W-1:0]   retired_q, retired_d, retired_inc;
   logic [WCW-1:0]     wcnt_q, wcnt_d, wcnt_inc;
   logic               illegal_q, illegal_d;
   logic               bus_err_q, bus_err_d;
   logic               wdog_hit;
   op_class_e          cls;

   assign cls         = op_classify(ir_q[OP_MSB:OP_LSB]);
   // Retired count sticks at all-ones rather than wrapping
   assign retired_inc = (&retired_q) ? retired_q : retired_q + 1'b1;
   assign wcnt_inc    = wcnt_q + 1'b1;
   // This cycle would be the WDOG_MAX-th consecutive one without the handshake
   assign wdog_hit    = (wcnt_inc == WCW'(WDOG_MAX));

   // State register and datapath registers; reset overrides every input
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         retired_q <= '0;
         wcnt_q    <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
         wcnt_q    <= wcnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Next-state logic; the wait counter clears whenever the handshake is not stalled
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      retired_d = retired_q;
      wcnt_d    = '0;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_d   = ST_FETCH;
               pc_d      = '0;
               illegal_d = 1'b0;
               bus_err_d = 1'b0;
            end
         end
         ST_FETCH: begin
            if (imem_valid) begin
               ir_d    = imem_data;
               state_d = ST_DECODE;
            end else if (wdog_hit) begin
               bus_err_d = 1'b1;
               state_d   = ST_HALT;
            end else begin
               wcnt_d = wcnt_inc;
            end
         end
         ST_DECODE: begin
            case (cls)
               CL_ALU:       state_d = ST_EXEC;
               CL_LI:        state_d = ST_WB;
               CL_LD, CL_ST: state_d = ST_MEM;
               CL_HALT:      state_d = ST_HALT;
               default: begin
                  illegal_d = 1'b1;
                  state_d   = ST_HALT;
               end
            endcase
         end
         ST_EXEC: state_d = ST_WB;
         ST_MEM: begin
            if (dmem_ack) begin
               if (cls == CL_ST) begin
                  // Stores retire here: nothing to write back
                  pc_d      = pc_q + 1'b1;
                  retired_d = retired_inc;
                  state_d   = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end else if (wdog_hit) begin
               bus_err_d = 1'b1;
               state_d   = ST_HALT;
            end else begin
               wcnt_d = wcnt_inc;
            end
         end
         ST_WB: begin
            pc_d      = pc_q + 1'b1;
            retired_d = retired_inc;
            state_d   = ST_FETCH;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Moore outputs decoded from the current state and latched opcode
   always_comb begin
      imem_req  = (state_q == ST_FETCH);
      dmem_req  = (state_q == ST_MEM);
      dmem_we   = (state_q == ST_MEM) && (cls == CL_ST);
      alu_go    = (state_q == ST_EXEC);
      rf_we     = (state_q == ST_WB);
      busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);
      rf_wr_sel = SEL_ALU;
      case (cls)
         CL_LI:   rf_wr_sel = SEL_IMM;
         CL_LD:   rf_wr_sel = SEL_MEM;
         default: rf_wr_sel = SEL_ALU;
      endcase
   end

   assign imem_addr  = pc_q;
   assign ir         = ir_q;
   assign rf_wr_addr = ir_q[RD_MSB:RD_LSB];
   assign retired    = retired_q;
   assign illegal    = illegal_q;
   assign bus_error  = bus_err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: memory responder with programmable waits plus write-back scoreboard.
// Latency: checks cycle counts from start to write-back and handshake durations.
// Backpressure: delays imem_valid/dmem_ack to exercise stalls and the watchdog.
module tb_instr_sequencer;
   import cpu_pkg::*;

   typedef struct packed {
      logic [2:0] addr;
      logic [1:0] sel;
   } wb_t;

   logic clk = 1'b0;
   logic reset;
   logic start;

   instr_sequencer_if bus();

   int checks = 0;
   int errors = 0;

   wb_t exp_q[$];
   wb_t obs_q[$];

   // Observations of the most recent exec_one call
   int   alu_cnt, dreq_cnt, we_cnt, fetch_cyc, wb_cyc;
   logic run_ok;

   // Reference model of architectural counters
   logic [7:0]  exp_pc;
   logic [15:0] exp_ret;

   always #5 clk = ~clk;

   instr_sequencer #(.WDOG_MAX(15)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .imem_req   (bus.imem_req),
      .imem_addr  (bus.imem_addr),
      .imem_valid (bus.imem_valid),
      .imem_data  (bus.imem_data),
      .ir         (bus.ir),
      .alu_go     (bus.alu_go),
      .dmem_req   (bus.dmem_req),
      .dmem_we    (bus.dmem_we),
      .dmem_ack   (bus.dmem_ack),
      .rf_we      (bus.rf_we),
      .rf_wr_addr (bus.rf_wr_addr),
      .rf_wr_sel  (bus.rf_wr_sel),
      .busy       (bus.busy),
      .illegal    (bus.illegal),
      .bus_error  (bus.bus_error),
      .retired    (bus.retired)
   );

   function automatic wb_t mk_wb(input logic [2:0] a, input logic [1:0] s);
      wb_t w;
      w.addr = a;
      w.sel  = s;
      return w;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      bus.imem_valid = 1'b0;
      bus.dmem_ack   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_pc  = 8'd0;
      exp_ret = 16'd0;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      exp_pc = 8'd0;
   endtask

   // Memory responder for one instruction, entered with the DUT in FETCH; returns at next FETCH or on halt
   task automatic exec_one(input logic [20:0] instr, input int imem_wait, input int dmem_wait);
      int   dw;
      int   cyc;
      logic left;
      wb_t  w;
      dw = 0; cyc = 0; left = 1'b0;
      alu_cnt = 0; dreq_cnt = 0; we_cnt = 0; fetch_cyc = 0; wb_cyc = -1; run_ok = 1'b0;
      bus.imem_data = instr;
      for (int c = 0; c < 300; c++) begin
         bus.imem_valid = bus.imem_req && (fetch_cyc >= imem_wait);
         bus.dmem_ack   = bus.dmem_req && (dw >= dmem_wait);
         if (bus.imem_req) fetch_cyc++;
         if (bus.dmem_req) dw++;
         @(posedge clk);
         #1;
         cyc++;
         if (bus.rf_we) begin
            w.addr = bus.rf_wr_addr;
            w.sel  = bus.rf_wr_sel;
            obs_q.push_back(w);
            if (wb_cyc < 0) wb_cyc = cyc;
         end
         if (bus.alu_go) alu_cnt++;
         if (bus.dmem_req) begin
            dreq_cnt++;
            if (bus.dmem_we) we_cnt++;
         end
         if (!bus.imem_req) left = 1'b1;
         if (!bus.busy || (bus.imem_req && left)) begin
            run_ok = 1'b1;
            break;
         end
      end
      bus.imem_valid = 1'b0;
      bus.dmem_ack   = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({bus.busy, bus.imem_req, bus.dmem_req, bus.dmem_we, bus.alu_go, bus.rf_we, bus.illegal, bus.bus_error} !== 8'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got busy,imem_req,dmem_req,dmem_we,alu_go,rf_we,illegal,bus_error=%b, expected 00000000",
                  {bus.busy, bus.imem_req, bus.dmem_req, bus.dmem_we, bus.alu_go, bus.rf_we, bus.illegal, bus.bus_error});
      end
      checks++;
      if (bus.retired !== 16'd0 || bus.ir !== 21'd0 || bus.imem_addr !== 8'd0) begin
         errors++;
         $display("FAIL reset_regs: got retired=%0h ir=%0h pc=%0h, expected all 0", bus.retired, bus.ir, bus.imem_addr);
      end
      reset = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_over_start: got busy=%b imem_req=%b, expected 0 0", bus.busy, bus.imem_req);
      end
   endtask

   task automatic test_li();
      wb_t e, o;
      do_start();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'd0) begin
         errors++;
         $display("FAIL li_fetch: got imem_req=%b addr=%0h, expected 1 0", bus.imem_req, bus.imem_addr);
      end
      exp_q.push_back(mk_wb(3'd3, SEL_IMM));
      exp_pc  = exp_pc + 8'd1;
      exp_ret = exp_ret + 16'd1;
      exec_one(21'h10C05A, 0, 0);
      checks++;
      if (run_ok !== 1'b1) begin errors++; $display("FAIL li_done: got done=%b, expected 1", run_ok); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL li_wb_count: got %0d write-backs, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL li_wb: got addr=%0d sel=%0d, expected addr=%0d sel=%0d", o.addr, o.sel, e.addr, e.sel);
         end
      end
      exp_q.delete(); obs_q.delete();
      checks++;
      if (wb_cyc + 2 !== 4) begin errors++; $display("FAIL li_latency: got start->WB %0d cycles, expected 4", wb_cyc + 2); end
      checks++;
      if (bus.retired !== exp_ret) begin errors++; $display("FAIL li_retired: got %0d, expected %0d", bus.retired, exp_ret); end
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
         errors++;
         $display("FAIL li_next_fetch: got imem_req=%b pc=%0d, expected 1 %0d", bus.imem_req, bus.imem_addr, exp_pc);
      end
      checks++;
      if (bus.ir !== 21'h10C05A) begin errors++; $display("FAIL li_ir: got %0h, expected 10c05a", bus.ir); end
   endtask

   task automatic test_alu();
      wb_t e, o;
      do_reset();
      do_start();
      exp_q.push_back(mk_wb(3'd1, SEL_ALU));
      exp_pc  = exp_pc + 8'd1;
      exp_ret = exp_ret + 16'd1;
      start = 1'b1;  // must be ignored while busy
      exec_one(21'h005300, 0, 0);
      start = 1'b0;
      checks++;
      if (run_ok !== 1'b1) begin errors++; $display("FAIL alu_done: got done=%b, expected 1", run_ok); end
      checks++;
      if (alu_cnt !== 1) begin errors++; $display("FAIL alu_go_pulses: got %0d, expected 1", alu_cnt); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL alu_wb_count: got %0d write-backs, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL alu_wb: got addr=%0d sel=%0d, expected addr=%0d sel=%0d", o.addr, o.sel, e.addr, e.sel);
         end
      end
      exp_q.delete(); obs_q.delete();
      checks++;
      if (bus.imem_addr !== exp_pc || bus.retired !== exp_ret) begin
         errors++;
         $display("FAIL alu_pc: got pc=%0d retired=%0d, expected %0d %0d", bus.imem_addr, bus.retired, exp_pc, exp_ret);
      end
   endtask

   task automatic test_mem();
      wb_t e, o;
      exp_q.push_back(mk_wb(3'd0, SEL_MEM));
      exp_pc  = exp_pc + 8'd1;
      exp_ret = exp_ret + 16'd1;
      exec_one(21'h120000, 0, 5);
      checks++;
      if (run_ok !== 1'b1) begin errors++; $display("FAIL ld_done: got done=%b, expected 1", run_ok); end
      checks++;
      if (dreq_cnt !== 6 || we_cnt !== 0) begin
         errors++;
         $display("FAIL ld_dmem: got req cycles=%0d we cycles=%0d, expected 6 0", dreq_cnt, we_cnt);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL ld_wb_count: got %0d write-backs, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL ld_wb: got addr=%0d sel=%0d, expected addr=%0d sel=%0d", o.addr, o.sel, e.addr, e.sel);
         end
      end
      exp_q.delete(); obs_q.delete();
      // Store: back to back, retires in MEM with no write-back
      exp_pc  = exp_pc + 8'd1;
      exp_ret = exp_ret + 16'd1;
      exec_one(21'h140000, 0, 0);
      checks++;
      if (dreq_cnt !== 1 || we_cnt !== 1) begin
         errors++;
         $display("FAIL st_dmem: got req cycles=%0d we cycles=%0d, expected 1 1", dreq_cnt, we_cnt);
      end
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL st_no_wb: got %0d write-backs, expected 0", obs_q.size()); end
      obs_q.delete();
      checks++;
      if (bus.imem_addr !== exp_pc || bus.retired !== exp_ret) begin
         errors++;
         $display("FAIL st_pc: got pc=%0d retired=%0d, expected %0d %0d", bus.imem_addr, bus.retired, exp_pc, exp_ret);
      end
   endtask

   task automatic test_halt_illegal();
      logic [3:0] ill_ops [5];
      ill_ops[0] = 4'h7; ill_ops[1] = 4'hB; ill_ops[2] = 4'hC; ill_ops[3] = 4'hD; ill_ops[4] = 4'hE;
      exec_one(21'h1E0000, 0, 0);
      checks++;
      if (bus.busy !== 1'b0 || bus.illegal !== 1'b0 || bus.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL halt_state: got busy=%b illegal=%b imem_req=%b, expected 0 0 0", bus.busy, bus.illegal, bus.imem_req);
      end
      checks++;
      if (bus.retired !== exp_ret) begin errors++; $display("FAIL halt_retired: got %0d, expected %0d", bus.retired, exp_ret); end
      for (int k = 0; k < 5; k++) begin
         do_start();
         exec_one({ill_ops[k], 17'h0}, 0, 0);
         checks++;
         if (bus.illegal !== 1'b1 || bus.busy !== 1'b0 || bus.retired !== exp_ret) begin
            errors++;
            $display("FAIL illegal_op_%0h: got illegal=%b busy=%b retired=%0d, expected 1 0 %0d",
                     ill_ops[k], bus.illegal, bus.busy, bus.retired, exp_ret);
         end
      end
      do_start();
      checks++;
      if (bus.illegal !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'd0) begin
         errors++;
         $display("FAIL illegal_clear: got illegal=%b imem_req=%b pc=%0d, expected 0 1 0", bus.illegal, bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_watchdog();
      wb_t e, o;
      exec_one(21'h10C05A, 100, 0);
      checks++;
      if (fetch_cyc !== 15 || bus.bus_error !== 1'b1 || bus.imem_req !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL wdog_fetch: got fetch cycles=%0d bus_error=%b imem_req=%b busy=%b, expected 15 1 0 0",
                  fetch_cyc, bus.bus_error, bus.imem_req, bus.busy);
      end
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL wdog_no_wb: got %0d write-backs, expected 0", obs_q.size()); end
      obs_q.delete();
      do_start();
      checks++;
      if (bus.bus_error !== 1'b0) begin errors++; $display("FAIL wdog_clear: got bus_error=%b, expected 0", bus.bus_error); end
      exp_q.push_back(mk_wb(3'd3, SEL_IMM));
      exec_one(21'h10C05A, 14, 0);
      checks++;
      if (fetch_cyc !== 15 || bus.bus_error !== 1'b0 || bus.imem_req !== 1'b1) begin
         errors++;
         $display("FAIL wdog_fetch_edge: got fetch cycles=%0d bus_error=%b imem_req=%b, expected 15 0 1",
                  fetch_cyc, bus.bus_error, bus.imem_req);
      end
      exp_q.push_back(mk_wb(3'd0, SEL_MEM));
      exec_one(21'h120000, 0, 14);
      checks++;
      if (dreq_cnt !== 15 || bus.bus_error !== 1'b0 || bus.imem_req !== 1'b1) begin
         errors++;
         $display("FAIL wdog_mem_edge: got req cycles=%0d bus_error=%b imem_req=%b, expected 15 0 1",
                  dreq_cnt, bus.bus_error, bus.imem_req);
      end
      exec_one(21'h120000, 0, 100);
      checks++;
      if (dreq_cnt !== 15 || bus.bus_error !== 1'b1 || bus.dmem_req !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL wdog_mem: got req cycles=%0d bus_error=%b dmem_req=%b busy=%b, expected 15 1 0 0",
                  dreq_cnt, bus.bus_error, bus.dmem_req, bus.busy);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL wdog_wb_count: got %0d write-backs, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL wdog_wb: got addr=%0d sel=%0d, expected addr=%0d sel=%0d", o.addr, o.sel, e.addr, e.sel);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid();
      do_start();
      bus.imem_data  = 21'h120000;
      bus.imem_valid = 1'b1;
      @(posedge clk); #1;
      bus.imem_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL rstmid_in_mem: got dmem_req=%b, expected 1", bus.dmem_req); end
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      start = 1'b1;
      bus.dmem_ack = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b0;
      bus.dmem_ack = 1'b0;
      checks++;
      if (bus.dmem_req !== 1'b0 || bus.rf_we !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_ctrl: got dmem_req=%b rf_we=%b busy=%b, expected 0 0 0", bus.dmem_req, bus.rf_we, bus.busy);
      end
      checks++;
      if (bus.retired !== 16'd0 || bus.imem_addr !== 8'd0 || bus.ir !== 21'd0) begin
         errors++;
         $display("FAIL rstmid_regs: got retired=%0d pc=%0d ir=%0h, expected 0 0 0", bus.retired, bus.imem_addr, bus.ir);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.rf_we !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_idle: got busy=%b rf_we=%b, expected 0 0", bus.busy, bus.rf_we);
      end
   endtask

   task automatic test_pc_wrap();
      wb_t e, o;
      int  fails;
      do_reset();
      do_start();
      fails = 0;
      for (int i = 0; i < 256; i++) begin
         if (i == 255) begin
            checks++;
            if (bus.imem_addr !== 8'd255) begin
               errors++;
               $display("FAIL wrap_pc255: got pc=%0d, expected 255", bus.imem_addr);
            end
         end
         exp_q.push_back(mk_wb(3'd3, SEL_IMM));
         exp_pc  = exp_pc + 8'd1;
         exp_ret = exp_ret + 16'd1;
         exec_one(21'h10C05A, 0, 0);
         if (run_ok !== 1'b1) fails++;
      end
      checks++;
      if (fails !== 0) begin errors++; $display("FAIL wrap_done: got %0d stalled instructions, expected 0", fails); end
      checks++;
      if (bus.imem_addr !== exp_pc || bus.imem_addr !== 8'd0) begin
         errors++;
         $display("FAIL wrap_pc: got pc=%0d, expected 0", bus.imem_addr);
      end
      checks++;
      if (bus.retired !== exp_ret) begin errors++; $display("FAIL wrap_retired: got %0d, expected %0d", bus.retired, exp_ret); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL wrap_wb_count: got %0d write-backs, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL wrap_wb: got addr=%0d sel=%0d, expected addr=%0d sel=%0d", o.addr, o.sel, e.addr, e.sel);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      reset          = 1'b1;
      start          = 1'b0;
      bus.imem_valid = 1'b0;
      bus.imem_data  = '0;
      bus.dmem_ack   = 1'b0;
      exp_pc         = 8'd0;
      exp_ret        = 16'd0;
      test_reset();
      test_li();
      test_alu();
      test_mem();
      test_halt_illegal();
      test_watchdog();
      test_reset_mid();
      test_pc_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter WDOG_MAX, default 15, meaning the number of wait cycles allowed on any memory handshake before a bus error.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: begin execution from IDLE or HALT.
REQ-005 SHALL have ports imem_req (output, 1), imem_addr (output, 8) and imem_valid (input, 1): instruction fetch handshake.
REQ-006 SHALL have port imem_data, input, 21 bits: fetched instruction.
REQ-007 SHALL have port ir, output, 21 bits: latched instruction driven to the decoder.
REQ-008 SHALL have port alu_go, output, 1 bit: one-cycle ALU strobe.
REQ-009 SHALL have ports dmem_req (output, 1), dmem_we (output, 1) and dmem_ack (input, 1): data memory handshake.
REQ-010 SHALL have ports rf_we (output, 1), rf_wr_addr (output, 3) and rf_wr_sel (output, 2): register write-back; rf_wr_sel 0=ALU, 1=immediate, 2=memory.
REQ-011 SHALL have ports busy (output, 1), illegal (output, 1), bus_error (output, 1) and retired (output, 16): status outputs.

Function
REQ-012 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-013 In IDLE and HALT, start=1 SHALL go to FETCH with pc=0 and SHALL clear illegal and bus_error; start SHALL be ignored in all other states.
REQ-014 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; when imem_valid=1, ir SHALL latch imem_data and the state SHALL go to DECODE.
REQ-015 DECODE SHALL last one cycle and branch on ir[20:17]: 0x0-0x6 go to EXEC; 0x8 goes to WB; 0x9 and 0xA go to MEM; 0xF goes to HALT; any other opcode sets illegal and goes to HALT.
REQ-016 EXEC SHALL assert alu_go for exactly one cycle, then go to WB with rf_wr_sel=0.
REQ-017 In MEM, dmem_req SHALL be 1, and dmem_we SHALL be 1 only for opcode 0xA.
REQ-018 On dmem_ack in MEM: a read (0x9) SHALL go to WB with rf_wr_sel=2; a write (0xA) SHALL increment pc and retired and go to FETCH, with no rf_we.
REQ-019 WB SHALL assert rf_we for one cycle with rf_wr_addr=ir[16:14], increment pc, increment retired, and go to FETCH; load-immediate SHALL use rf_wr_sel=1.
REQ-020 pc SHALL be 8 bits and wrap from 255 to 0.
REQ-021 retired SHALL saturate at 0xFFFF.
REQ-022 A wait counter SHALL count consecutive cycles in FETCH without imem_valid, or in MEM without dmem_ack.
REQ-023 When the wait counter reaches WDOG_MAX, bus_error SHALL set, requests SHALL drop that edge, and the state SHALL go to HALT.
REQ-024 If valid or ack arrives in the same cycle the counter reaches WDOG_MAX, the handshake SHALL complete and no error SHALL be raised.
REQ-025 busy SHALL be 1 in every state except IDLE and HALT.
REQ-026 The halt instruction (0xF) SHALL NOT increment retired.

Reset
REQ-027 When reset=1 at a clock edge, the state SHALL go to IDLE and pc, ir, retired and the wait counter SHALL go to 0.
REQ-028 On the same reset edge, imem_req, dmem_req, dmem_we, alu_go, rf_we, illegal and bus_error SHALL go to 0.
REQ-029 Reset SHALL take priority over start, imem_valid and dmem_ack, including when asserted mid-handshake; no write-back SHALL occur on the reset edge.

Structure
REQ-030 A shared package cpu_pkg SHALL hold the opcode constants (ALU 0x0-0x6, LI 0x8, LD 0x9, ST 0xA, HALT 0xF), the state enum, the rf_wr_sel encodings, and the instruction field bit ranges.
REQ-031 The block SHALL be a single module with no sub-modules; opcode classification SHALL be a function in cpu_pkg.

Verification
REQ-032 Scenario LI: imem_data=0x10C05A with zero-wait valid -> rf_we pulses with rf_wr_addr=3 and rf_wr_sel=1, retired=1, and FETCH restarts at pc=1; total cycles start->WB = 4.
REQ-033 Scenario ALU: imem_data=0x005300 -> alu_go pulses exactly once, then rf_we with rf_wr_addr=1 and rf_wr_sel=0, and pc=1.
REQ-034 Scenario memory: LD 0x120000 with dmem_ack delayed 5 cycles -> dmem_req held 6 cycles, dmem_we=0, and rf_wr_sel=2; ST 0x140000 -> dmem_we=1 and no rf_we.
REQ-035 Scenario halt/illegal: 0x1E0000 -> HALT, busy=0, illegal=0, retired unchanged; 0x0E0000 -> HALT with illegal=1; a subsequent start clears illegal.
REQ-036 Scenario watchdog: imem_valid held low -> bus_error=1 after 15 wait cycles and imem_req drops; imem_valid arriving on the 15th cycle -> no error.
REQ-037 Scenario reset: reset pulsed during a MEM wait -> dmem_req=0 on that edge, state IDLE, retired=0; and pc wrap 255->0 is checked after 256 LI instructions.
